memory_responder: RTL and testbench

MEMORY_RESPONDER -- requirements
Module: memory_responder

---
 rtl/mem_pkg.sv | 24 ++
 rtl/memory_bus.sv | 26 ++
 rtl/mem_bram.sv | 31 +++
 rtl/memory_responder.sv | 123 ++++++++++++
 tb/tb_memory_responder.sv | 244 ++++++++++++++++++++++++
 5 files changed

// File: rtl/mem_pkg.sv
// Shared definitions for the memory responder: bus defaults, IO window map and FSM states.
// The IO window is eight bytes at IO_BASE; offsets below are relative to it.
package mem_pkg;
    localparam int ADDR_W_DEF = 16;
    localparam int DATA_W_DEF = 8;

    localparam logic [15:0] IO_BASE     = 16'hFF00;
    localparam logic [2:0]  REG_CNT0    = 3'd0;
    localparam logic [2:0]  REG_CNT1    = 3'd1;
    localparam logic [2:0]  REG_CNT2    = 3'd2;
    localparam logic [2:0]  REG_CNT3    = 3'd3;
    localparam logic [2:0]  REG_SCRATCH = 3'd4;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        RD_WAIT = 2'd1,
        RD_DONE = 2'd2
    } state_t;

    // Little-endian byte select from a 32-bit word.
    function automatic logic [7:0] cnt_byte(input logic [31:0] v, input logic [1:0] idx);
        return 8'(v >> {idx, 3'b000});
    endfunction
endpackage

// File: rtl/memory_bus.sv
// CPU-to-memory request/response bus.
// Handshake: the initiator holds dispatch_read/dispatch_write with addr and write_data
// stable until a cycle in which busy=0; that cycle is the accept. Each accepted read
// produces exactly one read_valid pulse, with read_data valid only while it is high.
interface memory_bus import mem_pkg::*; #(
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int DATA_W = DATA_W_DEF
);
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] write_data;
    logic              dispatch_read;
    logic              dispatch_write;
    logic [DATA_W-1:0] read_data;
    logic              read_valid;
    logic              busy;

    modport responder (
        input  addr, write_data, dispatch_read, dispatch_write,
        output read_data, read_valid, busy
    );

    modport initiator (
        output addr, write_data, dispatch_read, dispatch_write,
        input  read_data, read_valid, busy
    );
endinterface

// File: rtl/mem_bram.sv
// Single-port write-first RAM with an LAT-stage registered read path.
// Contents are never reset; only the pipeline registers move every cycle.
module mem_bram #(
    parameter int DEPTH  = 32768,
    parameter int DATA_W = 8,
    parameter int LAT    = 2,
    parameter int AW     = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              we,
    input  logic [AW-1:0]     addr,
    input  logic [DATA_W-1:0] wdata,
    output logic [DATA_W-1:0] rdata
);
    logic [DATA_W-1:0] mem [DEPTH];
    logic [DATA_W-1:0] pipe [LAT];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[addr] <= wdata;
            pipe[0]   <= wdata;
        end else begin
            pipe[0]   <= mem[addr];
        end
        for (int i = 1; i < LAT; i++) begin
            pipe[i] <= pipe[i-1];
        end
    end

    assign rdata = pipe[LAT-1];
endmodule

// File: rtl/memory_responder.sv
// Memory responder: RAM below RAM_DEPTH, an 8-byte IO window at IO_BASE, zeros elsewhere.
// Writes complete in the accept cycle; reads return two cycles after accept.
module memory_responder import mem_pkg::*; #(
    parameter int ADDR_W    = ADDR_W_DEF,
    parameter int DATA_W    = DATA_W_DEF,
    parameter int RAM_DEPTH = 32768,
    parameter int RD_LAT    = 2
) (
    input  logic        clk_in,
    input  logic        rst_in,
    memory_bus.responder mem_bus,
    output logic [1:0]  dbg_state
);
    localparam int                BRAM_AW   = $clog2(RAM_DEPTH);
    localparam logic [31:0]       RAM_LIMIT = RAM_DEPTH;
    localparam logic [ADDR_W-1:0] IO_BASE_A = ADDR_W'(IO_BASE);

    state_t            state;
    logic              busy_q;
    logic              read_valid_q;
    logic [DATA_W-1:0] read_data_q;
    logic [DATA_W-1:0] io_data_q;
    logic              rd_is_ram;
    logic [31:0]       counter;
    logic [31:0]       snapshot;
    logic [DATA_W-1:0] scratch;

    logic              accept_rd;
    logic              accept_wr;
    logic              in_ram;
    logic              in_io;
    logic [2:0]        io_off;
    logic [DATA_W-1:0] io_rdata;
    logic [DATA_W-1:0] bram_dout;
    logic [DATA_W-1:0] read_mux;

    assign in_ram    = 32'(mem_bus.addr) < RAM_LIMIT;
    assign in_io     = mem_bus.addr[ADDR_W-1:3] == IO_BASE_A[ADDR_W-1:3];
    assign io_off    = mem_bus.addr[2:0];
    // A simultaneous read+write is taken as a write only.
    assign accept_wr = (state == IDLE) && mem_bus.dispatch_write;
    assign accept_rd = (state == IDLE) && mem_bus.dispatch_read && !mem_bus.dispatch_write;

    // Byte 0 comes from the live counter, the same value the snapshot captures this cycle.
    always_comb begin
        io_rdata = '0;
        if (in_io) begin
            if (io_off[2] == 1'b0) begin
                io_rdata = DATA_W'(cnt_byte((io_off == REG_CNT0) ? counter : snapshot, io_off[1:0]));
            end else if (io_off == REG_SCRATCH) begin
                io_rdata = scratch;
            end
        end
    end

    mem_bram #(
        .DEPTH  (RAM_DEPTH),
        .DATA_W (DATA_W),
        .LAT    (RD_LAT)
    ) u_bram (
        .clk   (clk_in),
        .we    (accept_wr && in_ram),
        .addr  (mem_bus.addr[BRAM_AW-1:0]),
        .wdata (mem_bus.write_data),
        .rdata (bram_dout)
    );

    assign read_mux = rd_is_ram ? bram_dout : io_data_q;

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            state        <= IDLE;
            busy_q       <= 1'b0;
            read_valid_q <= 1'b0;
            read_data_q  <= '0;
            io_data_q    <= '0;
            rd_is_ram    <= 1'b0;
            counter      <= '0;
            snapshot     <= '0;
            scratch      <= '0;
        end else begin
            counter <= counter + 32'd1;
            case (state)
                IDLE: begin
                    if (accept_wr) begin
                        if (in_io && io_off == REG_SCRATCH) begin
                            scratch <= mem_bus.write_data;
                        end
                    end else if (accept_rd) begin
                        state     <= RD_WAIT;
                        busy_q    <= 1'b1;
                        rd_is_ram <= in_ram;
                        io_data_q <= io_rdata;
                        if (in_io && io_off == REG_CNT0) begin
                            snapshot <= counter;
                        end
                    end
                end
                RD_WAIT: begin
                    state        <= RD_DONE;
                    read_valid_q <= 1'b1;
                end
                RD_DONE: begin
                    state        <= IDLE;
                    busy_q       <= 1'b0;
                    read_valid_q <= 1'b0;
                    read_data_q  <= read_mux;
                end
                default: begin
                    state        <= IDLE;
                    busy_q       <= 1'b0;
                    read_valid_q <= 1'b0;
                end
            endcase
        end
    end

    // RAM data arrives in RD_DONE itself, so the pulse cycle bypasses the hold register.
    assign mem_bus.read_data  = read_valid_q ? read_mux : read_data_q;
    assign mem_bus.read_valid = read_valid_q;
    assign mem_bus.busy       = busy_q;
    assign dbg_state          = state;
endmodule

// File: tb/tb_memory_responder.sv
// Directed bench for memory_responder: driver tasks push expected read data into a queue,
// a negedge monitor pops and compares on every read_valid.
module tb_memory_responder;
    import mem_pkg::*;

    localparam int AW = 16;
    localparam int DW = 8;

    logic       clk = 1'b0;
    logic       rst;
    logic [1:0] dbg_state;

    memory_bus #(.ADDR_W(AW), .DATA_W(DW)) bus ();

    memory_responder #(
        .ADDR_W    (AW),
        .DATA_W    (DW),
        .RAM_DEPTH (32768),
        .RD_LAT    (2)
    ) dut (
        .clk_in    (clk),
        .rst_in    (rst),
        .mem_bus   (bus),
        .dbg_state (dbg_state)
    );

    always #5 clk = ~clk;

    // Reference cycle count: the value the DUT counter must hold in each cycle.
    logic [31:0] ref_cyc;
    always @(posedge clk or posedge rst) begin
        if (rst) ref_cyc <= '0;
        else     ref_cyc <= ref_cyc + 32'd1;
    end

    logic [DW-1:0] exp_q[$];
    logic [31:0]   cyc_q[$];
    int            n_checks = 0;
    int            n_fail   = 0;
    int            valid_seen = 0;
    logic [DW-1:0] hold_exp = '0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor
    always @(negedge clk) begin
        logic [DW-1:0] e;
        logic [31:0]   c;
        if (rst) begin
            hold_exp = '0;
            check("reset_busy", 32'(bus.busy), 32'd0);
            check("reset_read_valid", 32'(bus.read_valid), 32'd0);
            check("reset_read_data", 32'(bus.read_data), 32'd0);
        end else if (bus.read_valid) begin
            valid_seen++;
            if (exp_q.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL stray_read_valid: got read_valid=1 data=0x%0h expected no pending read", bus.read_data);
            end else begin
                e = exp_q.pop_front();
                c = cyc_q.pop_front();
                check("read_data", 32'(bus.read_data), 32'(e));
                check("read_latency", ref_cyc, c + 32'd2);
                hold_exp = e;
            end
        end else begin
            check("read_data_hold", 32'(bus.read_data), 32'(hold_exp));
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_idle();
        int b = 0;
        while (bus.busy && b < 20) begin
            tick();
            b++;
        end
        if (bus.busy) begin
            n_checks++;
            n_fail++;
            $display("FAIL busy_timeout: got busy=1 expected busy=0 within 20 cycles");
        end
    endtask

    task automatic issue_write(input logic [AW-1:0] a, input logic [DW-1:0] d);
        wait_idle();
        bus.addr           = a;
        bus.write_data     = d;
        bus.dispatch_write = 1'b1;
        bus.dispatch_read  = 1'b0;
        check("busy_at_write", 32'(bus.busy), 32'd0);
        tick();
        bus.dispatch_write = 1'b0;
    endtask

    task automatic issue_read(input logic [AW-1:0] a, input logic [DW-1:0] e);
        wait_idle();
        bus.addr          = a;
        bus.dispatch_read = 1'b1;
        exp_q.push_back(e);
        cyc_q.push_back(ref_cyc);
        tick();
        bus.dispatch_read = 1'b0;
    endtask

    initial begin
        int          v0;
        int          busy_cnt;
        int          g;
        logic [31:0] snap;

        rst                = 1'b1;
        bus.addr           = '0;
        bus.write_data     = '0;
        bus.dispatch_read  = 1'b0;
        bus.dispatch_write = 1'b0;
        repeat (3) tick();
        check("reset_state", 32'(dbg_state), 32'(IDLE));
        rst = 1'b0;
        tick();

        // Write then read the next cycle
        issue_write(16'h0010, 8'hA5);
        issue_read(16'h0010, 8'hA5);

        // Back-to-back writes, plus RAM boundary and aliasing above RAM
        issue_write(16'h0000, 8'h12);
        issue_write(16'h7FFF, 8'hE7);
        issue_write(16'h8000, 8'h99);
        issue_write(16'h0011, 8'h5B);
        issue_read(16'h0000, 8'h12);
        issue_read(16'h7FFF, 8'hE7);
        issue_read(16'h8000, 8'h00);
        issue_read(16'h0011, 8'h5B);
        issue_read(16'h0010, 8'hA5);

        // Read held three cycles: one accept, one pulse, busy for two cycles
        issue_write(16'h0020, 8'h5A);
        wait_idle();
        v0                = valid_seen;
        bus.addr          = 16'h0020;
        bus.dispatch_read = 1'b1;
        exp_q.push_back(8'h5A);
        cyc_q.push_back(ref_cyc);
        busy_cnt = 0;
        for (int i = 0; i < 3; i++) begin
            busy_cnt += int'(bus.busy);
            tick();
        end
        bus.dispatch_read = 1'b0;
        check("held_read_busy_cycles", 32'(busy_cnt), 32'd2);
        repeat (4) tick();
        check("held_read_pulses", 32'(valid_seen - v0), 32'd1);

        // Read+write together is a write only
        wait_idle();
        v0                 = valid_seen;
        bus.addr           = 16'h0030;
        bus.write_data     = 8'h3C;
        bus.dispatch_read  = 1'b1;
        bus.dispatch_write = 1'b1;
        check("busy_at_rw", 32'(bus.busy), 32'd0);
        tick();
        bus.dispatch_read  = 1'b0;
        bus.dispatch_write = 1'b0;
        check("rw_stays_idle", 32'(bus.busy), 32'd0);
        repeat (4) tick();
        check("rw_no_read_valid", 32'(valid_seen), 32'(v0));
        issue_read(16'h0030, 8'h3C);

        // IO scratch, reserved IO bytes, unmapped space
        issue_read(16'hFF04, 8'h00);
        issue_write(16'hFF04, 8'h77);
        issue_read(16'hFF04, 8'h77);
        issue_read(16'h9000, 8'h00);
        issue_write(16'h9000, 8'h44);
        issue_read(16'h9000, 8'h00);
        issue_write(16'hFF05, 8'h11);
        issue_read(16'hFF05, 8'h00);
        issue_read(16'hFF07, 8'h00);
        issue_read(16'hFF08, 8'h00);
        issue_read(16'hFEFF, 8'h00);

        // Counter snapshot, taken just before the low byte wraps so byte 1 moves
        wait_idle();
        g = 0;
        while (ref_cyc[7:0] != 8'hFD && g < 300) begin
            tick();
            g++;
        end
        snap = ref_cyc;
        issue_read(16'hFF00, snap[7:0]);
        issue_read(16'hFF01, snap[15:8]);
        issue_read(16'hFF02, snap[23:16]);
        issue_read(16'hFF03, snap[31:24]);

        // Reset in RD_WAIT
        issue_write(16'h0040, 8'hC3);
        wait_idle();
        bus.addr          = 16'h0040;
        bus.dispatch_read = 1'b1;
        tick();
        bus.dispatch_read = 1'b0;
        check("rd_wait_busy", 32'(bus.busy), 32'd1);
        check("rd_wait_state", 32'(dbg_state), 32'(RD_WAIT));
        #1 rst = 1'b1;
        #1;
        check("abort_busy", 32'(bus.busy), 32'd0);
        check("abort_read_valid", 32'(bus.read_valid), 32'd0);
        check("abort_read_data", 32'(bus.read_data), 32'd0);
        check("abort_state", 32'(dbg_state), 32'(IDLE));
        tick();
        tick();
        rst = 1'b0;
        v0  = valid_seen;
        repeat (5) tick();
        check("no_stale_valid", 32'(valid_seen), 32'(v0));
        issue_read(16'h0040, 8'hC3);
        issue_read(16'hFF04, 8'h00);
        issue_read(16'h0010, 8'hA5);

        g = 0;
        while (exp_q.size() > 0 && g < 50) begin
            tick();
            g++;
        end
        check("pending_reads", 32'(exp_q.size()), 32'd0);
        repeat (2) tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
